// File: rtl/ser_tx_4.sv
// rtl/ser_tx_4.sv - 4-bit parallel-in serial transmitter (start, LSB-first data, optional parity, stop); optional parity via SER_TX_PARITY_EN
module ser_tx_4 #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_par,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

`ifdef SER_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] idx, idx_n;
  logic [3:0] sh, sh_n;
  logic       tx_n;
  logic       bit_end;
`ifdef SER_TX_PARITY_EN
  logic       par, par_n;
`endif

  assign bit_end    = (cnt == LAST);
  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // State, counters, captured word and the registered serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      tx_out <= 1'b1;
`ifdef SER_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh     <= sh_n;
      tx_out <= tx_n;
`ifdef SER_TX_PARITY_EN
      par    <= par_n;
`endif
    end
  end

  // Next-state logic; tx_n is the line level belonging to the next state so tx_out stays registered
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    done    = 1'b0;
`ifdef SER_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (load_valid) begin
          sh_n    = i_par;
          state_n = START;
`ifdef SER_TX_PARITY_EN
          par_n   = ^i_par;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          sh_n  = sh >> 1;
          idx_n = idx + 2'd1;
          if (idx == 2'd3) begin
`ifdef SER_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
`ifdef SER_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
`ifdef SER_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ser_tx_4.sv
// tb/tb_ser_tx_4.sv - self-checking bench for ser_tx_4 (table vectors, corner sequences, random vs queue model)
module tb_ser_tx_4;

`ifdef SER_TX_PARITY_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam int BCA = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_par;
  logic       load_valid;
  logic       load_ready, tx_out, busy, done;
  logic [3:0] ib;
  logic       vb;
  logic       rdy_b, tx_b, busy_b, done_b;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  ser_tx_4 #(.BIT_CYCLES(BCA)) dut_a (
    .clk(clk), .rst(rst), .i_par(i_par), .load_valid(load_valid),
    .load_ready(load_ready), .tx_out(tx_out), .busy(busy), .done(done)
  );

  ser_tx_4 #(.BIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .i_par(ib), .load_valid(vb),
    .load_ready(rdy_b), .tx_out(tx_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the in-flight frame as a queue of per-clock line levels
  logic q[$];

  function automatic void expand(input logic [3:0] w);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 4; i++) b.push_back(w[i]);
`ifdef SER_TX_PARITY_EN
    b.push_back(^w);
`endif
    b.push_back(1'b1);
    q.delete();
    foreach (b[i]) for (int k = 0; k < BCA; k++) q.push_back(b[i]);
  endfunction

  always @(posedge clk) begin
    if (rst) q.delete();
    else if (q.size() == 0) begin
      if (load_valid) expand(i_par);
    end else void'(q.pop_front());
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() == 0) begin
        chk("model_tx", tx_out, 1);
        chk("model_busy", busy, 0);
        chk("model_ready", load_ready, 1);
        chk("model_done", done, 0);
      end else begin
        chk("model_tx", tx_out, q[0]);
        chk("model_busy", busy, 1);
        chk("model_ready", load_ready, 0);
        chk("model_done", done, (q.size() == 1));
      end
    end
  end

  typedef struct {
    logic [3:0] word;
    logic [6:0] bits;  // bit k = k-th transmitted bit
  } vec_t;
  vec_t tbl[7];

  task automatic wait_idle();
    int n = 0;
    while (!load_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", load_ready, 1);
  endtask

  // Offer a word; returns at the negedge of clock 1 after the transfer edge
  task automatic send(input logic [3:0] w);
    wait_idle();
    load_valid = 1'b1;
    i_par = w;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_frame(input logic [6:0] bits, input bit toggle);
    for (int c = 1; c <= NB * BCA; c++) begin
      chk("frame_tx", tx_out, bits[(c - 1) / BCA]);
      chk("frame_done", done, (c == NB * BCA));
      chk("frame_busy", busy, 1);
      if (toggle) begin
        i_par = 4'b0000;
        load_valid = (c == NB * BCA) ? 1'b0 : ~load_valid;
      end
      @(negedge clk);
    end
  endtask

  logic [6:0] b0101, b1100, b1111, b1010, b0110;

  initial begin
`ifdef SER_TX_PARITY_EN
    tbl[0] = '{4'b1011, 7'b1110110};
    tbl[1] = '{4'b0011, 7'b1000110};
    tbl[2] = '{4'b0101, 7'b1001010};
    tbl[3] = '{4'b1100, 7'b1011000};
    tbl[4] = '{4'b1010, 7'b1010100};
    tbl[5] = '{4'b0000, 7'b1000000};
    tbl[6] = '{4'b1111, 7'b1011110};
    b0110 = 7'b1001100;
`else
    tbl[0] = '{4'b1011, 7'b0110110};
    tbl[1] = '{4'b0011, 7'b0100110};
    tbl[2] = '{4'b0101, 7'b0101010};
    tbl[3] = '{4'b1100, 7'b0111000};
    tbl[4] = '{4'b1010, 7'b0110100};
    tbl[5] = '{4'b0000, 7'b0100000};
    tbl[6] = '{4'b1111, 7'b0111110};
    b0110 = 7'b0101100;
`endif
    b0101 = tbl[2].bits;
    b1100 = tbl[3].bits;
    b1010 = tbl[4].bits;
    b1111 = tbl[6].bits;

    rst = 1'b1; load_valid = 1'b1; i_par = 4'b1111; vb = 1'b1; ib = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_busy_b", busy_b, 0);
    load_valid = 1'b0; vb = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", load_ready, 1);
    chk("ready_after_rst_b", rdy_b, 1);

    // Table of single frames, inputs scrambled after the transfer
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].word);
      load_valid = 1'b0;
      i_par = 4'($urandom);
      check_frame(tbl[i].bits, 0);
      chk("post_frame_busy", busy, 0);
    end

    // Back-to-back with load_valid held high
    send(4'b0101);
    i_par = 4'b1100;
    check_frame(b0101, 0);
    chk("gap_tx", tx_out, 1);
    chk("gap_ready", load_ready, 1);
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    check_frame(b1100, 0);

    // Reset during data bit 2
    send(4'b1111);
    load_valid = 1'b0;
    for (int c = 1; c < 14; c++) begin
      chk("pre_rst_tx", tx_out, b1111[(c - 1) / BCA]);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_tx", tx_out, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", load_ready, 1);
    chk("mid_rst_done", done, 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end

    // load_valid toggling with 0000 during a 1010 frame
    send(4'b1010);
    load_valid = 1'b0;
    check_frame(b1010, 1);
    for (int c = 0; c < 6; c++) begin
      chk("no_0000_frame", busy, 0);
      @(negedge clk);
    end

    // BIT_CYCLES=1 instance
    ib = 4'b0110; vb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vb = 1'b0; ib = 4'b0000;
    for (int c = 1; c <= NB; c++) begin
      chk("bc1_tx", tx_b, b0110[c - 1]);
      chk("bc1_done", done_b, (c == NB));
      chk("bc1_busy", busy_b, 1);
      @(negedge clk);
    end
    chk("bc1_idle", busy_b, 0);
    chk("bc1_ready", rdy_b, 1);

    // Random traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      load_valid = ($urandom_range(0, 2) == 0);
      i_par = 4'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    load_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_tx_4.md
SER_TX_4 -- requirements
Module: ser_tx_4

Interface
REQ-001 The block SHALL have parameter BIT_CYCLES, default 4, meaning clocks per serial bit (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_par, input, 4 bits: parallel data word from the upstream 4-bit shift register.
REQ-005 The block SHALL have port load_valid, input, 1 bit: upstream word on i_par is valid.
REQ-006 The block SHALL have port load_ready, output, 1 bit: block can accept a word this cycle.
REQ-007 The block SHALL have port tx_out, output, 1 bit: serial line; idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-010 The block SHALL transmit frames as start bit (0), i_par[0]..i_par[3] (LSB first), optional parity bit (REQ-027), stop bit (1), each bit held exactly BIT_CYCLES clocks.
REQ-011 The block SHALL implement FSM states IDLE, START, DATA, STOP, plus PARITY per REQ-027; encoding is free.
REQ-012 The block SHALL assert load_ready combinationally iff state is IDLE; a transfer occurs on a clock edge where load_valid and load_ready are both 1.
REQ-013 On transfer, the block SHALL capture i_par into an internal 4-bit shift register and enter START; later i_par changes SHALL NOT affect the frame.
REQ-014 tx_out SHALL be registered: first start-bit cycle is the cycle after the transfer edge.
REQ-015 A bit counter SHALL count 0..BIT_CYCLES-1; the state/bit advances on the edge where it equals BIT_CYCLES-1, then the counter returns to 0.
REQ-016 DATA SHALL use a 2-bit index 0..3, right-shifting the captured word once per data bit; DATA exits after index 3.
REQ-017 On the last cycle of STOP, done SHALL be 1 for exactly that cycle, and the next state SHALL be IDLE.
REQ-018 busy SHALL equal 1 in every state except IDLE.
REQ-019 load_valid while busy SHALL be ignored (no capture, no frame corruption); upstream holds the word until load_ready.
REQ-020 Back-to-back: a word offered continuously SHALL be accepted on the first IDLE cycle after done; the resulting gap of one idle-high cycle between frames is required.
REQ-021 With BIT_CYCLES=1, each bit SHALL last one clock and the frame SHALL be 6 clocks (7 with parity).

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL go to IDLE, clear counters and shift register, and set tx_out=1, busy=0, done=0.
REQ-023 Reset mid-frame SHALL abandon the frame with no done pulse; tx_out SHALL be 1 from the cycle following the reset edge.
REQ-024 rst SHALL take priority over a simultaneous load_valid; no word is accepted on a reset edge.
REQ-025 load_ready SHALL be 1 in the cycle after reset deasserts.
REQ-026 The block SHALL have no asynchronous reset paths.

Configuration
REQ-027 With macro SER_TX_PARITY_EN defined, the block SHALL insert state PARITY after DATA, sending even parity (XOR of the 4 data bits) for BIT_CYCLES clocks; frame = 7 bits.
REQ-028 Without SER_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; DATA goes directly to STOP; frame = 6 bits.

Verification
REQ-029 The bench SHALL check: reset, then accept 4'b1011, BIT_CYCLES=4 -> tx_out = 0,1,1,0,1,1, each for 4 clocks; done high on clock 24 after accept; busy high for clocks 1..24.
REQ-030 The bench SHALL check: with SER_TX_PARITY_EN, send 4'b1011 -> parity bit 1 inserted before stop; done on clock 28; with 4'b0011 -> parity bit 0.
REQ-031 The bench SHALL check: load_valid held high with 4'b0101 then 4'b1100 -> second accepted on the cycle after done; exactly one idle-high cycle between frames; no bit lost.
REQ-032 The bench SHALL check: rst pulsed during DATA bit 2 of 4'b1111 -> tx_out=1, busy=0, load_ready=1 next cycle; no done pulse.
REQ-033 The bench SHALL check: load_valid toggling with 4'b0000 during a 4'b1010 frame -> frame bits unchanged; 4'b0000 not transmitted unless still valid in IDLE.
REQ-034 The bench SHALL check: BIT_CYCLES=1, send 4'b0110 -> tx_out 0,0,1,1,0,1 on consecutive clocks; done on clock 6.
